mc_controller: RTL and testbench

- Multi-cycle sequencing controller for the MIPS core datapath; replaces the single-cycle combinational controller when PC, IR, MDR and regfile writes are spread over several cycles.
- Decodes opcode/func from the datapath IR and steps an FSM through FETCH/DECODE/EXEC/MEM/WB.
- Drives all datapath enables and muxes, and handshakes with a shared instruction/data memory port that may insert wait states.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_decode.sv | 33 +++
 rtl/mc_controller.sv | 209 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_controller shared definitions: state codes, opcode/func
// values, datapath select encodings and instruction classes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR,
    C_J, C_JAL, C_BEQ, C_ORI,
    C_LUI, C_LW, C_SW, C_ILL
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func classifier for mc_controller.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic       illegal
);

  wire r_type = (opcode == OP_RTYPE);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      r_type && func == FN_NOP:  cls = C_NOP;
      r_type && func == FN_ADDU: cls = C_ADDU;
      r_type && func == FN_SUBU: cls = C_SUBU;
      r_type && func == FN_JR:   cls = C_JR;
      opcode == OP_J:            cls = C_J;
      opcode == OP_JAL:          cls = C_JAL;
      opcode == OP_BEQ:          cls = C_BEQ;
      opcode == OP_ORI:          cls = C_ORI;
      opcode == OP_LUI:          cls = C_LUI;
      opcode == OP_LW:           cls = C_LW;
      opcode == OP_SW:           cls = C_SW;
      default:                   cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencing FSM with memory wait handling.
// Optional MC_PERF_COUNTERS_EN adds cycle/retire counters.
module mc_controller
  import mc_pkg::*;
#(
  parameter int IMEM_WAIT_MAX = 16,
  parameter int DMEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_is_instr,
  output logic       mem_we,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] npc_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [15:0] IMAX = 16'(IMEM_WAIT_MAX);
  localparam logic [15:0] DMAX = 16'(DMEM_WAIT_MAX);

  state_t      st, st_nx;
  iclass_t     cls;
  logic        dec_ill;
  logic [15:0] wait_cnt;
  logic [15:0] lim;
  logic        waiting, hit;
  logic [3:0]  alu_c;
  logic        src_c, ext_c;

  mc_decode u_dec (
    .opcode  (opcode),
    .func    (func),
    .cls     (cls),
    .illegal (dec_ill)
  );

  assign waiting = (st == S_FETCH || st == S_MEM) && !mem_ready;
  assign lim     = (st == S_FETCH) ? IMAX : DMAX;
  assign hit     = waiting && lim != 16'd0 && wait_cnt == lim - 16'd1;
  assign state   = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      st <= st_nx;
      if (st_nx != st)
        wait_cnt <= '0;
      else if (waiting && wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
      if (hit)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    alu_c = ALU_ADD;
    src_c = 1'b0;
    ext_c = 1'b0;
    unique case (1'b1)
      cls == C_SUBU: alu_c = ALU_SUB;
      cls == C_BEQ:  alu_c = ALU_SUB;
      cls == C_ORI: begin
        alu_c = ALU_OR;
        src_c = 1'b1;
      end
      cls == C_LUI: begin
        alu_c = ALU_LUI;
        src_c = 1'b1;
      end
      cls == C_LW || cls == C_SW: begin
        src_c = 1'b1;
        ext_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_nx        = st;
    mem_req      = 1'b0;
    mem_is_instr = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    npc_op       = NPC_SEQ;
    reg_we       = 1'b0;
    reg_dst      = DST_RT;
    mem_to_reg   = WD_ALU;
    alu_src      = 1'b0;
    alu_op       = ALU_ADD;
    ext_op       = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      if (st == S_EXEC || st == S_MEM) begin
        alu_op  = alu_c;
        alu_src = src_c;
        ext_op  = ext_c;
      end
      unique case (st)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            st_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          st_nx = S_FETCH;
          unique case (1'b1)
            dec_ill: begin
              illegal = 1'b1;
              pc_we   = 1'b1;
            end
            cls == C_NOP: pc_we = 1'b1;
            cls == C_J: begin
              pc_we  = 1'b1;
              npc_op = NPC_J;
            end
            cls == C_JR: begin
              pc_we  = 1'b1;
              npc_op = NPC_JR;
            end
            cls == C_JAL: st_nx = S_WB;
            default:      st_nx = S_EXEC;
          endcase
        end
        S_EXEC: begin
          unique case (1'b1)
            cls == C_BEQ: begin
              pc_we  = 1'b1;
              npc_op = zero ? NPC_BR : NPC_SEQ;
              st_nx  = S_FETCH;
            end
            cls == C_LW || cls == C_SW: st_nx = S_MEM;
            default:                    st_nx = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == C_SW);
          if (mem_ready) begin
            if (cls == C_SW) begin
              pc_we = 1'b1;
              st_nx = S_FETCH;
            end else begin
              mdr_we = 1'b1;
              st_nx  = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          st_nx  = S_FETCH;
          unique case (1'b1)
            cls == C_JAL: begin
              reg_dst    = DST_RA;
              mem_to_reg = WD_PC4;
              npc_op     = NPC_J;
            end
            cls == C_LW: mem_to_reg = WD_MDR;
            cls == C_ADDU || cls == C_SUBU: reg_dst = DST_RD;
            default: ;
          endcase
        end
        default: st_nx = S_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected
// output traces are built from the instruction-level rules.
module tb_mc_controller;

  localparam int LIM = 16;

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3;
  localparam int K_J = 4, K_JAL = 5, K_BEQ = 6, K_ORI = 7;
  localparam int K_LUI = 8, K_LW = 9, K_SW = 10, K_ILL = 11;

  typedef struct packed {
    logic [2:0] st;
    logic       req, instr, we, ir, mdr, pcw;
    logic [1:0] npc;
    logic       rw;
    logic [1:0] dst, m2r;
    logic       src;
    logic [3:0] alu;
    logic       ext, ill, to;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_is_instr, mem_we, ir_we, mdr_we, pc_we;
  logic [1:0] npc_op, reg_dst, mem_to_reg;
  logic       reg_we, alu_src, ext_op, illegal, mem_timeout;
  logic [3:0] alu_op;
  logic [2:0] state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   n_cyc = 0;
  int   n_ret = 0;
  logic sticky = 1'b0;
  obs_t exp_q[$];
  logic rdy_q[$];

  always #5 clk = ~clk;

  mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .func         (func),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_is_instr (mem_is_instr),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .npc_op       (npc_op),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .ext_op       (ext_op),
    .illegal      (illegal),
    .mem_timeout  (mem_timeout),
    .state        (state)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .retire_cnt   (retire_cnt)
`endif
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{state, mem_req, mem_is_instr, mem_we, ir_we, mdr_we,
          pc_we, npc_op, reg_we, reg_dst, mem_to_reg, alu_src,
          alu_op, ext_op, illegal, mem_timeout};
    return o;
  endfunction

  task automatic enc(input int k, output logic [5:0] op,
                     output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'h00;
    case (k)
      K_NOP:  fn = 6'h00;
      K_ADDU: fn = 6'h21;
      K_SUBU: fn = 6'h23;
      K_JR:   fn = 6'h08;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      K_BEQ:  op = 6'h04;
      K_ORI:  op = 6'h0D;
      K_LUI:  op = 6'h0F;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      default:
        if ($urandom_range(0, 1) == 1) begin
          while (fn inside {6'h00, 6'h08, 6'h21, 6'h23})
            fn = 6'($urandom);
        end else begin
          op = 6'($urandom);
          while (op inside {6'h00, 6'h02, 6'h03, 6'h04,
                            6'h0D, 6'h0F, 6'h23, 6'h2B})
            op = 6'($urandom);
        end
    endcase
  endtask

  // Expected trace: one entry per clock, plus the mem_ready to drive.
  task automatic model(input int k, input int fw, input int dw,
                       input logic z);
    obs_t e;
    logic [3:0] a = 4'd0;
    logic s = 1'b0, x = 1'b0;
    for (int j = 0; j <= fw; j++) begin
      e = '0; e.req = 1; e.instr = 1; e.ir = (j == fw);
      e.to = sticky || j >= LIM;
      exp_q.push_back(e); rdy_q.push_back(j == fw);
    end
    sticky = sticky || fw >= LIM;
    e = '0; e.st = 3'd1; e.to = sticky;
    case (k)
      K_NOP: e.pcw = 1;
      K_ILL: begin e.pcw = 1; e.ill = 1; end
      K_J:   begin e.pcw = 1; e.npc = 2; end
      K_JR:  begin e.pcw = 1; e.npc = 3; end
      default: ;
    endcase
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));
    if (e.pcw) return;
    if (k != K_JAL) begin
      case (k)
        K_SUBU, K_BEQ: a = 4'd1;
        K_ORI:  begin a = 4'd2; s = 1; end
        K_LUI:  begin a = 4'd3; s = 1; end
        K_LW, K_SW: begin s = 1; x = 1; end
        default: ;
      endcase
      e = '0; e.st = 3'd2; e.alu = a; e.src = s; e.ext = x;
      e.to = sticky;
      if (k == K_BEQ) begin e.pcw = 1; e.npc = z ? 2'd1 : 2'd0; end
      exp_q.push_back(e); rdy_q.push_back(1'($urandom));
      if (k == K_BEQ) return;
      if (k == K_LW || k == K_SW) begin
        for (int j = 0; j <= dw; j++) begin
          e = '0; e.st = 3'd3; e.req = 1; e.we = (k == K_SW);
          e.alu = a; e.src = s; e.ext = x;
          e.to = sticky || j >= LIM;
          if (j == dw) begin
            e.pcw = (k == K_SW);
            e.mdr = (k == K_LW);
          end
          exp_q.push_back(e); rdy_q.push_back(j == dw);
        end
        sticky = sticky || dw >= LIM;
        if (k == K_SW) return;
      end
    end
    e = '0; e.st = 3'd4; e.rw = 1; e.pcw = 1; e.to = sticky;
    if (k == K_JAL) begin e.dst = 2; e.m2r = 2; e.npc = 2; end
    if (k == K_ADDU || k == K_SUBU) e.dst = 1;
    if (k == K_LW) e.m2r = 1;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));
  endtask

  task automatic run(input string tag, input int k, input int fw,
                     input int dw, input logic z, input int limit);
    obs_t e, o;
    logic [5:0] op, fn;
    int n = 0;
    enc(k, op, fn);
    model(k, fw, dw, z);
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      opcode = op; func = fn; zero = z;
      mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      #1;
      o = sample();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s cyc%0d op=%h fn=%h got=%h exp=%h",
               tag, n, op, fn, o, e);
      end
`ifdef MC_PERF_COUNTERS_EN
      checks++;
      assert (cycle_cnt === n_cyc && retire_cnt === n_ret) else begin
        errors++;
        $error("FAIL %s perf got=%0d/%0d exp=%0d/%0d", tag,
               cycle_cnt, retire_cnt, n_cyc, n_ret);
      end
`endif
      n_cyc++;
      if (e.pcw) n_ret++;
      n++;
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    obs_t o;
    o = sample();
    checks++;
    assert (o === obs_t'('0)) else begin
      errors++;
      $error("FAIL %s got=%h exp=0", tag, o);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    sticky = 1'b0;
    n_cyc = 0;
    n_ret = 0;
  endtask

  initial begin
    int k, fw, dw;
    mem_ready = 1'b1;
    opcode = 6'h23;
    #3;
    chk_reset("reset_hold");
    @(posedge clk); #1;
    chk_reset("reset_edge");
    release_reset();

    run("addu", K_ADDU, 0, 0, 1'b0, 100);
    run("lw_w3", K_LW, 0, 3, 1'b0, 100);
    run("beq_z1", K_BEQ, 0, 0, 1'b1, 100);
    run("beq_z0", K_BEQ, 0, 0, 1'b0, 100);
    run("jal", K_JAL, 0, 0, 1'b0, 100);
    run("ill_rand", K_ILL, 0, 0, 1'b0, 100);

    @(negedge clk);
    opcode = 6'h3F; func = 6'h00; mem_ready = 1'b1;
    #1;
    checks++;
    assert (state === 3'd0 && ir_we === 1'b1) else begin
      errors++;
      $error("FAIL ill3f_fetch got=%0d/%b exp=0/1", state, ir_we);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    assert ({state, illegal, pc_we, npc_op} === {3'd1, 1'b1, 1'b1, 2'd0})
    else begin
      errors++;
      $error("FAIL ill3f_dec got=%b exp=%b",
             {state, illegal, pc_we, npc_op}, 7'b0011100);
    end
    n_cyc += 2;
    n_ret += 1;
    run("after_ill", K_NOP, 0, 0, 1'b0, 100);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 11));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      dw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run("rand", k, fw, dw, 1'($urandom), 100);
    end

    run("sw_w2", K_SW, 0, 2, 1'b0, 100);
    run("fetch_to", K_NOP, 18, 0, 1'b0, 100);
    run("sticky", K_ORI, 1, 0, 1'b0, 100);

    run("lw_abort", K_LW, 0, 6, 1'b0, 5);
    #1;
    reset = 1'b1;
    #1;
    chk_reset("async_mid_mem");
    @(posedge clk); #1;
    chk_reset("reset_after_edge");
    release_reset();
    run("post_reset", K_SUBU, 0, 0, 1'b0, 100);
    run("lui", K_LUI, 0, 0, 1'b0, 100);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
